// File: rtl/cursor_ctrl.sv
// Board cursor controller: synchronised, debounced push-buttons move an (x, y) cursor with wrap/saturate edges.
// Optional auto-repeat of held keys is enabled by defining CURSOR_AUTOREPEAT_EN.
module cursor_ctrl #(
    parameter int unsigned COLS          = 15,
    parameter int unsigned ROWS          = 15,
    parameter int unsigned XW            = 4,
    parameter int unsigned YW            = 4,
    parameter int unsigned DEB_CYCLES    = 250000,
    parameter int unsigned WRAP          = 1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_l,
    input  logic               key_r,
    input  logic               key_u,
    input  logic               key_d,
    input  logic               home,
    input  logic               lock,
    output logic [XW+YW-1:0]   loc,
    output logic               moved
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned KL = 0;
    localparam int unsigned KR = 1;
    localparam int unsigned KU = 2;
    localparam int unsigned KD = 3;

    logic [3:0]        raw;
    logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]        acc_q, acc_d, armed_q, armed_d, ev_q, ev_d;
    logic [3:0]        press, rep_ev;
    logic [DW-1:0]     deb_cnt_q [4];
    logic [DW-1:0]     deb_cnt_d [4];
    logic [1:0]        fill_q, fill_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [XW+YW-1:0]  loc_q, loc_d;
    logic              moved_q, moved_d;

    assign raw   = {key_d, key_u, key_r, key_l};
    assign x_q   = loc_q[XW-1:0];
    assign y_q   = loc_q[XW+YW-1:XW];
    assign loc   = loc_q;
    assign moved = moved_q;

    // Synchroniser, debouncer and press detection; a key only arms once it has been seen released after reset.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        acc_d   = acc_q;
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != acc_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    acc_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
        armed_d = armed_q | ({4{fill_q == 2'd2}} & sync2_q);
        press   = armed_q & acc_q & ~acc_d;
        ev_d    = press | rep_ev;
    end

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];
    logic [1:0]    rep_first_q, rep_first_d;
    logic [3:0]    held;

    // Per-axis repeat timer: restarts on any press of the axis, runs only while exactly one axis key is held.
    always_comb begin
        held   = ~acc_q & armed_q;
        rep_ev = '0;
        for (int a = 0; a < 2; a++) begin
            rep_cnt_d[a]   = '0;
            rep_first_d[a] = rep_first_q[a];
            if (press[2*a] || press[2*a+1]) begin
                rep_first_d[a] = 1'b1;
            end else if (held[2*a] ^ held[2*a+1]) begin
                if (rep_cnt_q[a] == (rep_first_q[a] ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1))) begin
                    rep_ev[2*a]    = held[2*a];
                    rep_ev[2*a+1]  = held[2*a+1];
                    rep_first_d[a] = 1'b0;
                end else begin
                    rep_cnt_d[a] = rep_cnt_q[a] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_cnt_q[0] <= '0;
            rep_cnt_q[1] <= '0;
            rep_first_q  <= '0;
        end else begin
            rep_cnt_q[0] <= rep_cnt_d[0];
            rep_cnt_q[1] <= rep_cnt_d[1];
            rep_first_q  <= rep_first_d;
        end
    end
`else
    assign rep_ev = '0;
`endif

    // Cursor update: home beats lock, lock discards events, opposite keys on one axis cancel.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (home) begin
            x_d = XW'(COLS / 2);
            y_d = YW'(ROWS / 2);
        end else if (!lock) begin
            if (ev_q[KR] && !ev_q[KL]) begin
                if (x_q == XW'(COLS - 1)) x_d = (WRAP != 0) ? '0 : x_q;
                else                      x_d = x_q + XW'(1);
            end else if (ev_q[KL] && !ev_q[KR]) begin
                if (x_q == '0) x_d = (WRAP != 0) ? XW'(COLS - 1) : x_q;
                else           x_d = x_q - XW'(1);
            end
            if (ev_q[KD] && !ev_q[KU]) begin
                if (y_q == YW'(ROWS - 1)) y_d = (WRAP != 0) ? '0 : y_q;
                else                      y_d = y_q + YW'(1);
            end else if (ev_q[KU] && !ev_q[KD]) begin
                if (y_q == '0) y_d = (WRAP != 0) ? YW'(ROWS - 1) : y_q;
                else           y_d = y_q - YW'(1);
            end
        end
        loc_d   = {y_d, x_d};
        moved_d = (loc_d != loc_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            acc_q     <= '1;
            armed_q   <= '0;
            fill_q    <= '0;
            ev_q      <= '0;
            loc_q     <= '0;
            moved_q   <= 1'b0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            acc_q     <= acc_d;
            armed_q   <= armed_d;
            fill_q    <= fill_d;
            ev_q      <= ev_d;
            loc_q     <= loc_d;
            moved_q   <= moved_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: a wrapping instance and a saturating instance share the same stimulus.
module tb_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_l = 1'b1, key_r = 1'b1, key_u = 1'b1, key_d = 1'b1;
    logic       home = 1'b0, lock = 1'b0;
    logic [7:0] loc_m, loc_s;
    logic       moved_m, moved_s;

    int passed = 0;
    int total  = 0;
    int mv_m   = 0;
    int mv_s   = 0;

    always #5 clk = ~clk;

    cursor_ctrl #(.COLS(15), .ROWS(15), .XW(4), .YW(4), .DEB_CYCLES(4), .WRAP(1),
                  .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) u_wrap (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .key_u(key_u), .key_d(key_d),
        .home(home), .lock(lock), .loc(loc_m), .moved(moved_m));

    cursor_ctrl #(.COLS(15), .ROWS(15), .XW(4), .YW(4), .DEB_CYCLES(4), .WRAP(0),
                  .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) u_sat (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .key_u(key_u), .key_d(key_d),
        .home(home), .lock(lock), .loc(loc_s), .moved(moved_s));

    typedef struct {
        logic [3:0] keys;   // {d, u, r, l}, 1 = pressed
        logic       hm;
        logic       lk;
        int         hold;
        int         ex, ey, emv;
        int         sx, sy, smv;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (moved_m) mv_m++;
        if (moved_s) mv_s++;
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_d, key_u, key_r, key_l} = ~k;
    endtask

    task automatic apply(input logic [3:0] k, input logic hm, input logic lk, input int hold);
        mv_m = 0;
        mv_s = 0;
        set_keys(k);
        home = hm;
        lock = lk;
        repeat (hold) step();
        set_keys(4'b0000);
        home = 1'b0;
        lock = 1'b0;
        repeat (14) step();
    endtask

    function automatic int ydiag(input int k);
`ifdef CURSOR_AUTOREPEAT_EN
        if (k < 6)  return 0;
        if (k < 26) return 1;
        return 2 + (k - 26) / 8;
`else
        return (k < 6) ? 0 : 1;
`endif
    endfunction

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 10,  0,  0, 1,  0,  0, 1};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 10, 14,  0, 1,  0,  0, 0};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 10,  0,  0, 1,  1,  0, 1};
        vecs[3]  = '{4'b0100, 1'b0, 1'b0, 10,  0, 14, 1,  1,  0, 0};
        vecs[4]  = '{4'b1000, 1'b0, 1'b0, 10,  0,  0, 1,  1,  1, 1};
        vecs[5]  = '{4'b0011, 1'b0, 1'b0, 10,  0,  0, 0,  1,  1, 0};
        vecs[6]  = '{4'b1010, 1'b0, 1'b0, 10,  1,  1, 1,  2,  2, 1};
        vecs[7]  = '{4'b1100, 1'b0, 1'b0, 10,  1,  1, 0,  2,  2, 0};
        vecs[8]  = '{4'b0010, 1'b0, 1'b1, 10,  1,  1, 0,  2,  2, 0};
        vecs[9]  = '{4'b0001, 1'b0, 1'b0,  3,  1,  1, 0,  2,  2, 0};
        vecs[10] = '{4'b0000, 1'b1, 1'b0,  3,  7,  7, 1,  7,  7, 1};
        vecs[11] = '{4'b0000, 1'b1, 1'b0,  3,  7,  7, 0,  7,  7, 0};

        // Reset state
        repeat (3) step();
        check("reset_loc_wrap", int'(loc_m), 0);
        check("reset_loc_sat", int'(loc_s), 0);
        check("reset_moved", int'(moved_m), 0);
        reset = 1'b1;
        repeat (2) step();

        // Press latency: first sampling edge N, update at N+6
        mv_m = 0;
        key_r = 1'b0;
        repeat (6) step();
        check("lat_before_loc", int'(loc_m), 0);
        check("lat_before_moved", int'(moved_m), 0);
        step();
        check("lat_loc", int'(loc_m), 8'h01);
        check("lat_moved", int'(moved_m), 1);
        step();
        check("lat_moved_pulse", int'(moved_m), 0);
        repeat (3) step();
        key_r = 1'b1;
        repeat (14) step();
        check("lat_single_move", mv_m, 1);
        check("lat_loc_final", int'(loc_m), 8'h01);
        check("lat_sat_loc", int'(loc_s), 8'h01);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].keys, vecs[i].hm, vecs[i].lk, vecs[i].hold);
            check($sformatf("vec%0d_wrap_x", i), int'(loc_m[3:0]), vecs[i].ex);
            check($sformatf("vec%0d_wrap_y", i), int'(loc_m[7:4]), vecs[i].ey);
            check($sformatf("vec%0d_wrap_moves", i), mv_m, vecs[i].emv);
            check($sformatf("vec%0d_sat_x", i), int'(loc_s[3:0]), vecs[i].sx);
            check($sformatf("vec%0d_sat_y", i), int'(loc_s[7:4]), vecs[i].sy);
            check($sformatf("vec%0d_sat_moves", i), mv_s, vecs[i].smv);
        end

        // Walk down from y=7: wrap instance wraps to 0, saturating one sticks at 14
        for (int i = 0; i < 8; i++) begin
            apply(4'b1000, 1'b0, 1'b0, 10);
            if (i == 7) begin
                check("ywrap_last_moves", mv_m, 1);
                check("ysat_last_moves", mv_s, 0);
            end
        end
        check("ywrap_loc", int'(loc_m), 8'h07);
        check("ysat_loc", int'(loc_s), 8'hE7);

        // Reset mid-debounce with key held through reset release
        key_r = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        check("rst_mid_loc_wrap", int'(loc_m), 0);
        check("rst_mid_loc_sat", int'(loc_s), 0);
        reset = 1'b1;
        mv_m = 0;
        mv_s = 0;
        repeat (12) step();
        key_r = 1'b1;
        repeat (12) step();
        check("held_thru_reset_moves", mv_m + mv_s, 0);
        check("held_thru_reset_loc", int'(loc_m), 0);
        apply(4'b0010, 1'b0, 1'b0, 10);
        check("repress_loc", int'(loc_m), 8'h01);
        check("repress_moves", mv_m, 1);

        // Home latency of one edge
        home = 1'b1;
        step();
        check("home_loc", int'(loc_m), 8'h77);
        check("home_moved", int'(moved_m), 1);
        step();
        check("home_held_moved", int'(moved_m), 0);
        home = 1'b0;
        step();

        // Held down key from y=0
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        key_d = 1'b0;
        for (int s = 1; s <= 67; s++) begin
            step();
            if (int'(loc_m[7:4]) != ydiag(s - 1))
                check($sformatf("hold_y_k%0d", s - 1), int'(loc_m[7:4]), ydiag(s - 1));
            else
                check("hold_y", int'(loc_m[7:4]), ydiag(s - 1));
        end
        key_d = 1'b1;
        repeat (15) step();
        check("hold_y_final", int'(loc_m[7:4]), ydiag(66));
        check("hold_sat_y_final", int'(loc_s[7:4]), ydiag(66));
        check("hold_x", int'(loc_m[3:0]), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
